// File: rtl/relay_link_arbiter_pkg.sv
// relay_link_arbiter_pkg: shared relay-path encodings and default timing constants
package relay_link_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_e;
  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;
  localparam int HOLD_CYCLES_DEF  = 64;
  localparam int GUARD_CYCLES_DEF = 16;
  localparam int MAX_GRANT_DEF    = 4096;
endpackage

// File: rtl/relay_rr_pick.sv
// relay_rr_pick: two-way round-robin picker, a tie goes to the side not served last
module relay_rr_pick
  import relay_link_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_served,
  output logic grant_valid,
  output logic winner
);
  assign grant_valid = req_a | req_b;
  assign winner      = (req_a & req_b) ? ~last_served : (req_b ? DIR_B : DIR_A);
endmodule

// File: rtl/relay_link_arbiter.sv
// relay_link_arbiter: half-duplex arbiter sharing one relay encoder between reader and tag sides
module relay_link_arbiter
  import relay_link_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int MAX_GRANT    = MAX_GRANT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic data_a,
  input  logic data_b,
  output logic enc_data,
  output logic enc_reset,
  output logic dir,
  output logic busy,
  output logic timeout
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(GUARD_CYCLES + 1);
  localparam int GW = $clog2(MAX_GRANT + 1);
  state_e state_q, state_d;
  logic dir_q, dir_d, last_q, last_d;
  logic enc_data_q, enc_data_d, enc_reset_q, enc_reset_d;
  logic busy_q, busy_d, timeout_q, timeout_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] guard_q, guard_d;
  logic [GW-1:0] grant_q, grant_d;
  logic grant_valid, winner, bit_in, at_max, exit_grant;
  relay_rr_pick u_pick (
    .req_a      (enable & data_a),
    .req_b      (enable & data_b),
    .last_served(last_q),
    .grant_valid(grant_valid),
    .winner     (winner)
  );
  assign bit_in     = dir_q ? data_b : data_a;
  assign at_max     = grant_q == GW'(MAX_GRANT);
  assign exit_grant = !enable || at_max || (hold_q == HW'(1) && !bit_in);
  // Next-state, counter and output computation; encoder defaults to reset and zero data
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    last_d      = last_q;
    hold_d      = hold_q;
    guard_d     = guard_q;
    grant_d     = grant_q;
    enc_reset_d = 1'b1;
    enc_data_d  = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: if (grant_valid) begin
        state_d     = GRANT;
        dir_d       = winner;
        last_d      = winner;
        enc_reset_d = 1'b0;
        enc_data_d  = 1'b1;
        hold_d      = HW'(HOLD_CYCLES);
        grant_d     = GW'(1);
      end
      GRANT: if (exit_grant) begin
        state_d   = GUARD;
        timeout_d = enable && at_max;
        guard_d   = DW'(GUARD_CYCLES);
      end else begin
        enc_reset_d = 1'b0;
        enc_data_d  = bit_in;
        hold_d      = bit_in ? HW'(HOLD_CYCLES) : (hold_q == '0 ? '0 : hold_q - HW'(1));
        grant_d     = grant_q + GW'(1);
      end
      GUARD: begin
        guard_d = guard_q - DW'(1);
        state_d = guard_q == DW'(1) ? IDLE : GUARD;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // State and output registers; reset leaves A winning the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dir_q       <= DIR_A;
      last_q      <= DIR_B;
      hold_q      <= '0;
      guard_q     <= '0;
      grant_q     <= '0;
      enc_data_q  <= 1'b0;
      enc_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      guard_q     <= guard_d;
      grant_q     <= grant_d;
      enc_data_q  <= enc_data_d;
      enc_reset_q <= enc_reset_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end
  // Flag illegal parameter values during simulation
  always @(posedge clk) begin
    assert (HOLD_CYCLES >= 2 && GUARD_CYCLES >= 2 && MAX_GRANT >= 2)
      else $error("relay_link_arbiter: all parameters must be >= 2");
  end
  assign enc_data  = enc_data_q;
  assign enc_reset = enc_reset_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
endmodule
